// File: rtl/cursor_blink_timer.sv
// Cursor blink generator: CB high for on_len cycles, low for off_len cycles, with restart/stop/hold.
// Optional blink-count limit with a done pulse when built with CURSOR_BLINK_LIMIT_EN.
module cursor_blink_timer #(
  parameter int WIDTH       = 24,
  parameter int ON_DEFAULT  = 6000000,
  parameter int OFF_DEFAULT = 6000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             stop,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] on_len_in,
  input  logic [WIDTH-1:0] off_len_in,
  output logic             CB,
  output logic             phase_tog,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
`ifdef CURSOR_BLINK_LIMIT_EN
  ,
  input  logic [15:0]      max_blinks,
  output logic             done
`endif
);

  // state | meaning
  // IDLE  | not blinking, cursor off
  // ON    | cursor visible, counting on_len cycles
  // OFF   | cursor hidden, counting off_len cycles
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ON_RST  = (ON_DEFAULT == 0) ? ONE : WIDTH'(ON_DEFAULT);
  localparam logic [WIDTH-1:0] OFF_RST = (OFF_DEFAULT == 0) ? ONE : WIDTH'(OFF_DEFAULT);

  logic [1:0]       state;
  logic [WIDTH-1:0] cur_len;
  logic [WIDTH-1:0] on_len;
  logic [WIDTH-1:0] off_len;
  logic             phase_end;

`ifdef CURSOR_BLINK_LIMIT_EN
  logic [15:0] blink_limit;
  logic [15:0] blink_tally;
  logic        last_blink;

  assign last_blink = (blink_limit != 16'd0) && ((blink_tally + 16'd1) == blink_limit);
`endif

  assign phase_end = (cnt == (cur_len - ONE));

  // A zero length would never terminate a phase, so it is stored as 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      on_len  <= ON_RST;
      off_len <= OFF_RST;
    end else if (load) begin
      on_len  <= (on_len_in == '0) ? ONE : on_len_in;
      off_len <= (off_len_in == '0) ? ONE : off_len_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cur_len   <= '0;
      CB        <= 1'b0;
      busy      <= 1'b0;
      phase_tog <= 1'b0;
`ifdef CURSOR_BLINK_LIMIT_EN
      blink_limit <= 16'd0;
      blink_tally <= 16'd0;
      done        <= 1'b0;
`endif
    end else begin
      phase_tog <= 1'b0;
`ifdef CURSOR_BLINK_LIMIT_EN
      done <= 1'b0;
`endif
      if (stop) begin
        state   <= S_IDLE;
        cnt     <= '0;
        cur_len <= '0;
        CB      <= 1'b0;
        busy    <= 1'b0;
`ifdef CURSOR_BLINK_LIMIT_EN
        blink_tally <= 16'd0;
`endif
      end else if (init) begin
        state   <= S_ON;
        cnt     <= '0;
        cur_len <= on_len;
        CB      <= 1'b1;
        busy    <= 1'b1;
`ifdef CURSOR_BLINK_LIMIT_EN
        blink_tally <= 16'd0;
        blink_limit <= max_blinks;
`endif
      end else if (!hold && (state != S_IDLE)) begin
        if (phase_end) begin
          phase_tog <= 1'b1;
          cnt       <= '0;
          if (state == S_ON) begin
            state   <= S_OFF;
            cur_len <= off_len;
            CB      <= 1'b0;
          end else begin
`ifdef CURSOR_BLINK_LIMIT_EN
            if (last_blink) begin
              state   <= S_IDLE;
              cur_len <= '0;
              CB      <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              if (blink_limit != 16'd0) blink_tally <= blink_tally + 16'd1;
              state   <= S_ON;
              cur_len <= on_len;
              CB      <= 1'b1;
            end
`else
            state   <= S_ON;
            cur_len <= on_len;
            CB      <= 1'b1;
`endif
          end
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cursor_blink_timer.sv
// Bench for cursor_blink_timer: directed scenarios with literal expectations plus random stimulus
// checked every cycle against a remaining-cycles model. Honours CURSOR_BLINK_LIMIT_EN.
module tb_cursor_blink_timer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init = 1'b0, stop = 1'b0, hold = 1'b0, load = 1'b0;
  logic [W-1:0] on_len_in = '0, off_len_in = '0;
  logic CB, phase_tog, busy;
  logic [W-1:0] cnt;
`ifdef CURSOR_BLINK_LIMIT_EN
  logic [15:0] max_blinks = 16'd0;
  logic done;
`endif

  int total = 0;
  int bad = 0;

  cursor_blink_timer #(.WIDTH(W), .ON_DEFAULT(4), .OFF_DEFAULT(3)) dut (
    .clk(clk), .rst(rst), .init(init), .stop(stop), .hold(hold), .load(load),
    .on_len_in(on_len_in), .off_len_in(off_len_in),
    .CB(CB), .phase_tog(phase_tog), .busy(busy), .cnt(cnt)
`ifdef CURSOR_BLINK_LIMIT_EN
    , .max_blinks(max_blinks), .done(done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 visible, 2 hidden; m_left counts cycles still to spend in the phase.
  int m_mode = 0, m_left = 0, m_len = 0, m_on = 4, m_off = 3;
  int m_tog = 0, m_done = 0, m_blinks = 0, m_max = 0;
  int n_on, n_off;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_left = 0; m_len = 0; m_on = 4; m_off = 3;
      m_tog = 0; m_done = 0; m_blinks = 0; m_max = 0;
    end else begin
      n_on = m_on;
      n_off = m_off;
      if (load) begin
        n_on  = (on_len_in == 0) ? 1 : int'(on_len_in);
        n_off = (off_len_in == 0) ? 1 : int'(off_len_in);
      end
      m_tog = 0;
      m_done = 0;
      if (stop) begin
        m_mode = 0;
      end else if (init) begin
        m_mode = 1; m_len = m_on; m_left = m_len; m_blinks = 0;
`ifdef CURSOR_BLINK_LIMIT_EN
        m_max = int'(max_blinks);
`else
        m_max = 0;
`endif
      end else if (!hold && m_mode != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_tog = 1;
          if (m_mode == 1) begin
            m_mode = 2; m_len = m_off; m_left = m_len;
          end else begin
            m_blinks++;
            if (m_max != 0 && m_blinks == m_max) begin
              m_mode = 0; m_done = 1;
            end else begin
              m_mode = 1; m_len = m_on; m_left = m_len;
            end
          end
        end
      end
      m_on = n_on;
      m_off = n_off;
    end
  end

  always @(negedge clk) begin
    check("cb", CB, (m_mode == 1) ? 1 : 0);
    check("busy", busy, (m_mode != 0) ? 1 : 0);
    check("tog", phase_tog, m_tog);
    check("cnt", cnt, (m_mode != 0) ? (m_len - m_left) : 0);
`ifdef CURSOR_BLINK_LIMIT_EN
    check("done", done, m_done);
`endif
  end

  bit [14:0] cb15, tg15;
  bit [15:0] cb16;
  bit [13:0] dn14;
  int n;
  bit found, busy_all;

  initial begin
    @(negedge clk);
    check("rst_cb", CB, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt, 0);
    check("rst_tog", phase_tog, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // default 4/3 blink
    init = 1'b1; @(negedge clk); init = 1'b0;
    busy_all = 1'b1;
    for (int k = 0; k < 15; k++) begin
      cb15[k] = CB; tg15[k] = phase_tog; busy_all &= busy;
      @(negedge clk);
    end
    check("t1_cb_pattern", cb15, 15'b100011110001111);
    check("t1_tog_pattern", tg15, 15'b100100010010000);
    check("t1_busy", busy_all, 1);

    // load mid-ON affects only later phases
    init = 1'b1; @(negedge clk); init = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cb16[k] = CB;
      if (k == 1) begin
        check("t2_cnt_at_load", cnt, 1);
        load = 1'b1; on_len_in = 8'd2; off_len_in = 8'd5;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    check("t2_cb_pattern", cb16, 16'h060F);

    // hold in OFF at cnt=2
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (busy && !CB && cnt == 8'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("t3_hold_wait", found, 1);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_hold_cnt", cnt, 2);
      check("t3_hold_cb", CB, 0);
    end
    hold = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!CB && n < 20);
    check("t3_resume_cycles", n, 3);

    // stop wins over init
    stop = 1'b1; init = 1'b1; @(negedge clk); stop = 1'b0; init = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_cb", CB, 0);
    check("t4_cnt", cnt, 0);
    @(negedge clk);
    check("t4_idle_stays", busy, 0);
    init = 1'b1; @(negedge clk); init = 1'b0;
    check("t4_restart_cb", CB, 1);
    check("t4_restart_cnt", cnt, 0);
    check("t4_restart_tog", phase_tog, 0);

    // zero lengths become 1: toggle every cycle
    load = 1'b1; on_len_in = '0; off_len_in = '0; @(negedge clk); load = 1'b0;
    init = 1'b1; @(negedge clk); init = 1'b0;
    check("t5_first_tog", phase_tog, 0);
    check("t5_first_cb", CB, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t5_tog", phase_tog, 1);
      check("t5_cb", CB, (k % 2 == 0) ? 1 : 0);
    end

    // maximum length phase
    load = 1'b1; on_len_in = 8'd255; off_len_in = 8'd1; @(negedge clk); load = 1'b0;
    init = 1'b1; @(negedge clk); init = 1'b0;
    n = 0;
    while (CB && n < 300) begin
      n++; @(negedge clk);
    end
    check("t6_on_cycles", n, 255);
    check("t6_off_cnt", cnt, 0);
    @(negedge clk);
    check("t6_back_on", CB, 1);

`ifdef CURSOR_BLINK_LIMIT_EN
    stop = 1'b1; load = 1'b1; on_len_in = 8'd3; off_len_in = 8'd3;
    @(negedge clk);
    stop = 1'b0; load = 1'b0; max_blinks = 16'd2; init = 1'b1;
    @(negedge clk); init = 1'b0;
    for (int k = 0; k < 14; k++) begin
      dn14[k] = done;
      @(negedge clk);
    end
    check("t7_done_pattern", dn14, 14'b01000000000000);
    check("t7_cb_after", CB, 0);
    check("t7_busy_after", busy, 0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      stop = ($urandom % 40) == 0;
      init = ($urandom % 25) == 0;
      hold = ($urandom % 6) == 0;
      load = ($urandom % 15) == 0;
      on_len_in  = (i % 700 == 3) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 6));
      off_len_in = 8'($urandom_range(0, 6));
`ifdef CURSOR_BLINK_LIMIT_EN
      max_blinks = 16'($urandom_range(0, 3));
`endif
      if (i == 1500) begin
        #2 rst = 1'b0;
        #1;
        check("async_rst_cb", CB, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_cnt", cnt, 0);
        @(negedge clk);
        rst = 1'b1;
      end
      @(negedge clk);
    end
    stop = 1'b0; init = 1'b0; hold = 1'b0; load = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cursor_blink_timer.md
Name: cursor_blink_timer

Overview:
- Parametrised cursor-blink generator for the paint FSM; successor to the fixed white-count blink counter.
- Produces cursor-visible level CB with independently programmable ON and OFF phase lengths in clock cycles.
- Adds restart, stop, hold, run-time period load, phase-change strobe and counter visibility.
- Sits between the paint controller (init/stop/hold) and the pixel mux that overlays the cursor.

Parameters:
- WIDTH, 24, width of phase counter and period registers.
- ON_DEFAULT, 6000000, ON-phase length after reset, in cycles.
- OFF_DEFAULT, 6000000, OFF-phase length after reset, in cycles.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- init  in  1  start/restart blinking.
- stop  in  1  return to IDLE, cursor off.
- hold  in  1  freeze counter, state and CB.
- load  in  1  write on_len_in/off_len_in into period registers.
- on_len_in  in  WIDTH  new ON length.
- off_len_in  in  WIDTH  new OFF length.
- CB  out  1  cursor visible (1 during ON phase).
- phase_tog  out  1  one-cycle pulse on every ON->OFF and OFF->ON transition.
- busy  out  1  high in ON or OFF state.
- cnt  out  WIDTH  current phase counter value.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, CB=0, phase_tog=0, busy=0, cnt=0, on_len=ON_DEFAULT, off_len=OFF_DEFAULT, cur_len=0.
- States: IDLE, ON, OFF. CB=1 only in ON. busy=1 in ON or OFF. All outputs registered.
- Period registers: on load=1, on_len<=on_len_in and off_len<=off_len_in the next cycle. A loaded value of 0 is stored as 1. load is accepted in any state.
- cur_len is latched at phase entry: on_len on entry to ON, off_len on entry to OFF. A load during a phase affects only the next phase entry.
- Priority each cycle: stop > init > hold > count.
- stop=1: next cycle IDLE, CB=0, cnt=0, phase_tog=0. Any pending phase end is discarded.
- init=1 with stop=0, in any state: next cycle ON, cnt=0, cur_len=on_len, CB=1. phase_tog=0, since a restart is not a toggle. This re-syncs a running blink.
- hold=1 (no stop/init): state, cnt, CB and cur_len unchanged; phase_tog=0.
- Counting, ON or OFF with no stop/init/hold:
  - if cnt==cur_len-1: switch phase, cnt<=0, cur_len<=new phase length, phase_tog=1 for that cycle;
  - otherwise cnt<=cnt+1.
  - Result: CB is high exactly on_len cycles and low exactly off_len cycles per period.
- Length 1: the phase lasts one cycle, so phase_tog is high continuously while both lengths are 1.
- IDLE ignores hold. cnt stays 0.
- Counter never wraps: cur_len-1 ≤ 2^WIDTH-2 is always reached first.
- load and init in the same cycle: init uses the old on_len. The new values apply from the next phase entry.

Optional Feature:
- Macro: CURSOR_BLINK_LIMIT_EN.
- With the macro defined:
  - Adds input max_blinks [15:0], sampled on init.
  - Adds output done (1 bit, reset 0).
  - A blink is one completed OFF phase.
  - After max_blinks complete blinks, the OFF->ON transition goes to IDLE instead; done pulses for 1 cycle and phase_tog still pulses.
  - max_blinks=0 means unlimited.
  - stop and init clear the blink tally; stop does not assert done.
- Without the macro: no extra ports, and blinking is unlimited until stop.

Test Plan:
- Reset release with ON_DEFAULT=4, OFF_DEFAULT=3, then 1-cycle init -> CB high 4 cycles, low 3, repeating. phase_tog pulses at cycles 4, 7, 11, 14 after ON entry. busy=1.
- load on_len_in=2, off_len_in=5 mid-ON (cnt=1 of 4) -> current ON completes 4 cycles, then OFF 5, ON 2, OFF 5.
- hold for 10 cycles at cnt=2 in OFF -> cnt stays 2 and CB stays 0, then resumes. Total OFF = off_len+10.
- stop and init asserted together while running -> next cycle IDLE, CB=0, busy=0, cnt=0. A later init alone restarts ON with cnt=0.
- load with on_len_in=0, off_len_in=0, then init -> CB alternates every cycle and phase_tog stays 1 continuously.
- CURSOR_BLINK_LIMIT_EN, max_blinks=2, lengths 3/3, init -> two full periods, then IDLE. done pulses once, 12 cycles after ON entry. CB=0 afterwards.
